dfifo_rd_ctrl: RTL and testbench
================================

DFIFO_RD_CTRL -- requirements
Module: dfifo_rd_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 4, RAM address width, range 4-10.
REQ-002 SHALL have parameter DATA_WIDTH, default 240, word width, range 1-256.
REQ-003 SHALL have parameter AEMPTY_TH, default 2, almost_empty threshold in RAM words.
REQ-004 SHALL have port rd_clk, input, 1, the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port wr_ptr, input, ADDR_WIDTH+1, write-side extended pointer (MSB = wrap bit), same clock domain.
REQ-007 SHALL have port rd_addr, output, ADDR_WIDTH, read address to the distributed SDP RAM (combinational-read, OUT_REG=0).
REQ-008 SHALL have port ram_rd_data, input, DATA_WIDTH, RAM read data for rd_addr, same cycle.
REQ-009 SHALL have port rd_ptr, output, ADDR_WIDTH+1, extended read pointer returned to the write side.
REQ-010 SHALL have port flush, input, 1, synchronous discard of all buffered data.
REQ-011 SHALL have ports m_valid (output, 1), m_ready (input, 1) and m_data (output, DATA_WIDTH), forming the output stream.
REQ-012 SHALL have ports empty (output, 1), almost_empty (output, 1), rd_count (output, ADDR_WIDTH+1) and ptr_err (output, 1, sticky).

Function
REQ-013 rd_count SHALL equal (wr_ptr - rd_ptr) mod 2^(ADDR_WIDTH+1), combinational; it is RAM occupancy, excluding the output register.
REQ-014 empty SHALL be (rd_count == 0); almost_empty SHALL be (rd_count <= AEMPTY_TH); both combinational.
REQ-015 rd_addr SHALL equal rd_ptr[ADDR_WIDTH-1:0] at all times.
REQ-016 Output stage SHALL be a two-state FSM: IDLE (m_valid=0) and HOLD (m_valid=1).
REQ-017 A load SHALL occur when the FIFO is not empty and the FSM is in IDLE, or in HOLD with m_ready=1.
REQ-018 On a load, m_data SHALL take ram_rd_data, rd_ptr SHALL increment by 1 with natural wrap at 2^(ADDR_WIDTH+1), and the FSM SHALL go to or stay in HOLD.
REQ-019 A HOLD with m_ready=1 and empty=1 SHALL go to IDLE; m_data SHALL then hold its last value.
REQ-020 In HOLD with m_ready=0, m_data and m_valid SHALL remain stable and rd_ptr SHALL not change.
REQ-021 Latency: a word whose write raises wr_ptr at edge N SHALL appear on m_data with m_valid=1 after edge N+1, when the stage was in IDLE.
REQ-022 Sustained throughput SHALL be 1 word/cycle while the FIFO is not empty and m_ready=1.
REQ-023 flush=1 SHALL, at the next edge, set rd_ptr to wr_ptr and force IDLE; flush SHALL override a simultaneous load or consume.
REQ-024 ptr_err SHALL set when rd_count > 2^ADDR_WIDTH, and SHALL clear only on rst.
REQ-025 No load SHALL occur in any cycle where rd_count > 2^ADDR_WIDTH.
REQ-026 Word order out SHALL equal write order, including across the pointer-wrap boundary.

Reset
REQ-027 rst SHALL asynchronously drive: rd_ptr=0, FSM=IDLE, m_valid=0, m_data=0 and ptr_err=0.
REQ-028 rst asserted mid-transfer SHALL discard the held word; after release, the first load SHALL read address 0.

Structure
REQ-029 The FSM state encoding and a ptr_diff width function SHALL live in the shared package dfifo_pkg, reused by the write controller.
REQ-030 The block SHALL be instantiated beside the ipm_distributed_sdpram instance with OUT_REG=0.
REQ-031 The block SHALL contain no sub-module; the RAM SHALL remain external.

Verification
REQ-032 Scenario: reset, then write 5 words (0xA0..0xA4) with m_ready=1 -> first m_valid 1 cycle after the first write, 5 consecutive beats in order, final rd_ptr=5.
REQ-033 Scenario: write 16 words with m_ready=0 -> m_valid=1 holding word 0, rd_count=15, empty=0; then m_ready=1 -> 16 beats with no bubbles, ending empty=1.
REQ-034 Scenario: pointers at 30, write 4 words -> rd_addr sequence 14,15,0,1, rd_ptr wraps 31->0->1->2, data in order.
REQ-035 Scenario: m_ready toggled every cycle over 8 words -> no word lost or duplicated, and m_data stable while m_ready=0.
REQ-036 Scenario: flush with 6 words buffered and m_ready=1 on the same cycle -> next cycle m_valid=0, rd_ptr=wr_ptr, rd_count=0.
REQ-037 Scenario: force wr_ptr = rd_ptr+17 -> ptr_err=1 with no load; rst -> ptr_err=0, rd_ptr=0.

Source files
------------

// File: rtl/dfifo_pkg.sv
// -----------------------------------------------------------------------------
// dfifo_pkg
// Shared definitions for the distributed-RAM FIFO read and write controllers.
//   rd_state_e      : output-stage state encoding (IDLE = no word held,
//                     HOLD = word presented on the stream interface)
//   ptr_diff_width  : width of an extended pointer / pointer difference for a
//                     given RAM address width (one extra wrap bit)
// -----------------------------------------------------------------------------
package dfifo_pkg;

  typedef enum logic [0:0] {
    RD_IDLE = 1'b0,
    RD_HOLD = 1'b1
  } rd_state_e;

  // Extended pointers carry one wrap bit above the RAM address so that a
  // full RAM (difference 2^addr_width) is distinguishable from an empty one.
  function automatic int ptr_diff_width(input int addr_width);
    return addr_width + 1;
  endfunction

endpackage

// File: rtl/dfifo_rd_ctrl.sv
// -----------------------------------------------------------------------------
// dfifo_rd_ctrl
// Read-side controller of a single-clock FIFO built around an external
// distributed simple-dual-port RAM with a combinational read port. The
// controller walks the read pointer, pulls words out of the RAM into a
// one-word output register and presents them as a valid/ready stream.
//
// Parameters
//   ADDR_WIDTH  RAM address width (4..10)
//   DATA_WIDTH  word width (1..256)
//   AEMPTY_TH   almost_empty threshold in RAM words
//
// Ports
//   rd_clk       in   clock, all logic on the rising edge
//   rst          in   asynchronous active-high reset
//   wr_ptr       in   write-side extended pointer (MSB = wrap bit)
//   rd_addr      out  RAM read address (low bits of rd_ptr)
//   ram_rd_data  in   RAM read data for rd_addr, same cycle
//   rd_ptr       out  extended read pointer returned to the write side
//   flush        in   synchronous discard of all buffered data
//   m_valid      out  output stream valid
//   m_ready      in   output stream ready
//   m_data       out  output stream data
//   empty        out  RAM holds no unread word
//   almost_empty out  RAM occupancy <= AEMPTY_TH
//   rd_count     out  RAM occupancy (output register not included)
//   ptr_err      out  sticky: pointer difference exceeded the RAM depth
// -----------------------------------------------------------------------------
module dfifo_rd_ctrl
  import dfifo_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 240,
  parameter int AEMPTY_TH  = 2
) (
  input  logic                  rd_clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH:0]   wr_ptr,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] ram_rd_data,
  output logic [ADDR_WIDTH:0]   rd_ptr,
  input  logic                  flush,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  empty,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   rd_count,
  output logic                  ptr_err
);

  localparam int PTR_W = ptr_diff_width(ADDR_WIDTH);

  // Occupancy equal to the RAM depth is legal (full); anything above it means
  // the pointers have diverged.
  localparam logic [PTR_W-1:0] DEPTH_C   = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [PTR_W-1:0] AEMPTY_C  = AEMPTY_TH[PTR_W-1:0];
  localparam logic [PTR_W-1:0] PTR_ONE_C = {{ADDR_WIDTH{1'b0}}, 1'b1};

  rd_state_e             state_r;
  logic [PTR_W-1:0]      rd_ptr_r;
  logic                  m_valid_r;
  logic [DATA_WIDTH-1:0] m_data_r;
  logic                  ptr_err_r;

  logic [PTR_W-1:0]      rd_count_s;
  logic                  empty_s;
  logic                  aempty_s;
  logic                  ptr_bad_s;
  logic                  load_s;

  // Occupancy and status flags; modular subtraction handles the wrap bit.
  always_comb begin
    rd_count_s = wr_ptr - rd_ptr_r;
    empty_s    = (rd_count_s == {PTR_W{1'b0}});
    aempty_s   = (rd_count_s <= AEMPTY_C);
    ptr_bad_s  = (rd_count_s > DEPTH_C);
  end

  // Load decision: the output register can accept a word when it is idle or
  // its current word is being consumed; never load from a corrupt pointer pair.
  always_comb begin
    load_s = 1'b0;
    if (!empty_s && !ptr_bad_s) begin
      if (state_r == RD_IDLE) begin
        load_s = 1'b1;
      end else if (m_ready) begin
        load_s = 1'b1;
      end else begin
        load_s = 1'b0;
      end
    end else begin
      load_s = 1'b0;
    end
  end

  // Output-stage FSM with registered pointer, valid and data.
  always_ff @(posedge rd_clk or posedge rst) begin
    if (rst) begin
      state_r   <= RD_IDLE;
      rd_ptr_r  <= {PTR_W{1'b0}};
      m_valid_r <= 1'b0;
      m_data_r  <= {DATA_WIDTH{1'b0}};
    end else if (flush) begin
      // Flush wins over any load or consume in the same cycle; the held data
      // value is left as is since m_valid drops.
      state_r   <= RD_IDLE;
      rd_ptr_r  <= wr_ptr;
      m_valid_r <= 1'b0;
    end else begin
      case (state_r)
        RD_IDLE: begin
          if (load_s) begin
            m_data_r  <= ram_rd_data;
            rd_ptr_r  <= rd_ptr_r + PTR_ONE_C;
            m_valid_r <= 1'b1;
            state_r   <= RD_HOLD;
          end else begin
            m_valid_r <= 1'b0;
            state_r   <= RD_IDLE;
          end
        end
        RD_HOLD: begin
          if (load_s) begin
            // Back-to-back: consume and refill in one cycle.
            m_data_r  <= ram_rd_data;
            rd_ptr_r  <= rd_ptr_r + PTR_ONE_C;
            m_valid_r <= 1'b1;
            state_r   <= RD_HOLD;
          end else if (m_ready) begin
            // Consumed with nothing to follow; data keeps its last value.
            m_valid_r <= 1'b0;
            state_r   <= RD_IDLE;
          end else begin
            m_valid_r <= 1'b1;
            state_r   <= RD_HOLD;
          end
        end
        default: begin
          m_valid_r <= 1'b0;
          state_r   <= RD_IDLE;
        end
      endcase
    end
  end

  // Sticky pointer-divergence flag, cleared only by reset.
  always_ff @(posedge rd_clk or posedge rst) begin
    if (rst) begin
      ptr_err_r <= 1'b0;
    end else if (ptr_bad_s) begin
      ptr_err_r <= 1'b1;
    end else begin
      ptr_err_r <= ptr_err_r;
    end
  end

  assign rd_ptr       = rd_ptr_r;
  assign rd_addr      = rd_ptr_r[ADDR_WIDTH-1:0];
  assign m_valid      = m_valid_r;
  assign m_data       = m_data_r;
  assign ptr_err      = ptr_err_r;
  assign rd_count     = rd_count_s;
  assign empty        = empty_s;
  assign almost_empty = aempty_s;

endmodule

// File: tb/tb_dfifo_rd_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dfifo_rd_ctrl
// Self-checking bench for dfifo_rd_ctrl. The bench plays the write side and
// the RAM; a queue of unread words plus a one-word "held" slot serves as the
// reference for what the output stream must show each cycle.
// -----------------------------------------------------------------------------
module tb_dfifo_rd_ctrl;

  localparam int AW    = 4;
  localparam int DW    = 16;
  localparam int AE    = 2;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW:0]   wr_ptr = '0;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] ram_rd_data;
  logic [AW:0]   rd_ptr;
  logic          flush = 1'b0;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [DW-1:0] m_data;
  logic          empty;
  logic          almost_empty;
  logic [AW:0]   rd_count;
  logic          ptr_err;

  logic [DW-1:0] mem [DEPTH];

  int checks   = 0;
  int failures = 0;
  int beats    = 0;

  // Reference: words written but not yet taken into the output register.
  logic [DW-1:0] q [$];
  logic          exp_valid;
  logic [DW-1:0] exp_data;
  logic [AW:0]   exp_rdptr;

  always #5 clk = ~clk;

  assign ram_rd_data = mem[rd_addr];

  dfifo_rd_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .AEMPTY_TH(AE)) dut (
    .rd_clk(clk), .rst(rst), .wr_ptr(wr_ptr), .rd_addr(rd_addr),
    .ram_rd_data(ram_rd_data), .rd_ptr(rd_ptr), .flush(flush),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .empty(empty),
    .almost_empty(almost_empty), .rd_count(rd_count), .ptr_err(ptr_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    q.delete();
    exp_valid = 1'b0;
    exp_data  = '0;
    exp_rdptr = '0;
  endtask

  // Write side: put a word in the RAM and advance wr_ptr (as if at the last edge).
  task automatic wr(input logic [DW-1:0] d);
    mem[wr_ptr[AW-1:0]] = d;
    q.push_back(d);
    wr_ptr = wr_ptr + 1'b1;
  endtask

  // One clock: advance the reference, then compare all observable outputs.
  task automatic tick();
    if (m_valid === 1'b1 && m_ready && !flush) beats++;
    if (flush) begin
      q.delete();
      exp_rdptr = wr_ptr;
      exp_valid = 1'b0;
    end else if (q.size() > 0 && (!exp_valid || m_ready)) begin
      exp_data  = q.pop_front();
      exp_valid = 1'b1;
      exp_rdptr = exp_rdptr + 1'b1;
    end else if (exp_valid && m_ready) begin
      exp_valid = 1'b0;
    end
    @(posedge clk);
    #1;
    chk("m_valid", 64'(m_valid), 64'(exp_valid));
    chk("m_data", 64'(m_data), 64'(exp_data));
    chk("rd_ptr", 64'(rd_ptr), 64'(exp_rdptr));
    chk("rd_addr", 64'(rd_addr), 64'(exp_rdptr % DEPTH));
    chk("rd_count", 64'(rd_count), 64'(q.size()));
    chk("empty", 64'(empty), 64'(q.size() == 0));
    chk("almost_empty", 64'(almost_empty), 64'(q.size() <= AE));
    chk("ptr_err", 64'(ptr_err), 64'd0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_async_valid", 64'(m_valid), 64'd0);
    chk("rst_async_rdptr", 64'(rd_ptr), 64'd0);
    chk("rst_async_data", 64'(m_data), 64'd0);
    chk("rst_async_err", 64'(ptr_err), 64'd0);
    @(posedge clk);
    #1;
    rst     = 1'b0;
    wr_ptr  = '0;
    flush   = 1'b0;
    m_ready = 1'b0;
    model_clear();
  endtask

  initial begin
    model_clear();
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;

    // Initial reset.
    do_reset();
    tick();
    chk("reset_empty", 64'(empty), 64'd1);

    // Five words streamed with m_ready high.
    m_ready = 1'b1;
    beats = 0;
    for (int i = 0; i < 5; i++) begin
      wr(DW'(16'hA0 + i));
      tick();
      chk("s1_beat_valid", 64'(m_valid), 64'd1);
      chk("s1_beat_data", 64'(m_data), 64'(16'hA0 + i));
    end
    for (int i = 0; i < 3; i++) tick();
    chk("s1_beats", 64'(beats), 64'd5);
    chk("s1_rd_ptr", 64'(rd_ptr), 64'd5);

    // Sixteen words with back-pressure, then drain without bubbles.
    m_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      wr(DW'($urandom));
      tick();
    end
    chk("s2_count", 64'(rd_count), 64'd15);
    chk("s2_valid", 64'(m_valid), 64'd1);
    chk("s2_empty", 64'(empty), 64'd0);
    m_ready = 1'b1;
    beats = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (i < 15) chk("s2_no_bubble", 64'(m_valid), 64'd1);
    end
    chk("s2_beats", 64'(beats), 64'd16);
    chk("s2_end_empty", 64'(empty), 64'd1);
    chk("s2_end_valid", 64'(m_valid), 64'd0);

    // m_ready toggling every cycle over eight words.
    beats = 0;
    for (int i = 0; i < 30; i++) begin
      logic [DW-1:0] prev;
      logic          held;
      if (i < 8) wr(DW'($urandom));
      m_ready = i[0];
      prev = m_data;
      held = m_valid && !m_ready;
      tick();
      if (held) chk("s4_stable", 64'(m_data), 64'(prev));
    end
    chk("s4_beats", 64'(beats), 64'd8);

    // Flush with six words buffered and a simultaneous consume.
    m_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      wr(DW'($urandom));
      tick();
    end
    flush = 1'b1;
    m_ready = 1'b1;
    tick();
    flush = 1'b0;
    chk("s5_valid", 64'(m_valid), 64'd0);
    chk("s5_ptr_eq", 64'(rd_ptr), 64'(wr_ptr));
    chk("s5_count", 64'(rd_count), 64'd0);
    tick();

    // Mid-transfer reset discards the held word; next load reads address 0.
    m_ready = 1'b0;
    wr(DW'(16'h1234));
    wr(DW'(16'h5678));
    tick();
    do_reset();
    mem[0] = DW'(16'h00C3);
    wr(DW'(16'h00C3));
    chk("s6_addr0", 64'(rd_addr), 64'd0);
    tick();
    chk("s6_first", 64'(m_data), 64'h00C3);

    // Pointer wrap: stream 34 words, rd_ptr passes 30,31,0,1,2.
    do_reset();
    m_ready = 1'b1;
    for (int i = 0; i < 34; i++) begin
      wr(DW'(16'h3000 + i));
      tick();
      if (i >= 29) chk("s3_wrap_addr", 64'(rd_addr), 64'((i + 1) % DEPTH));
    end
    tick();
    chk("s3_final_ptr", 64'(rd_ptr), 64'd2);

    // Randomized traffic with occasional flushes.
    for (int i = 0; i < 400; i++) begin
      m_ready = 1'($urandom_range(0, 1));
      flush   = ($urandom_range(0, 24) == 0);
      if (q.size() < DEPTH && $urandom_range(0, 2) != 0) wr(DW'($urandom));
      tick();
    end
    flush = 1'b0;
    m_ready = 1'b1;
    for (int i = 0; i < DEPTH + 2; i++) tick();

    // Diverged pointers: error flag sets, nothing loads.
    do_reset();
    wr_ptr = rd_ptr + 5'd17;
    @(posedge clk);
    #1;
    chk("s7_err", 64'(ptr_err), 64'd1);
    chk("s7_no_load_valid", 64'(m_valid), 64'd0);
    chk("s7_no_load_ptr", 64'(rd_ptr), 64'd0);
    chk("s7_count", 64'(rd_count), 64'd17);
    @(posedge clk);
    #1;
    chk("s7_err_sticky", 64'(ptr_err), 64'd1);
    chk("s7_still_idle", 64'(m_valid), 64'd0);
    do_reset();
    chk("s7_err_cleared", 64'(ptr_err), 64'd0);
    chk("s7_ptr_cleared", 64'(rd_ptr), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
